// File: rtl/apb_master_engine_pkg.sv
// Shared types and defaults for the APB master engine.
//   ADDR_WIDTH_DEF/DATA_WIDTH_DEF/NBYTES_DEF : default bus widths
//   apb_cmd_t / apb_rsp_t                    : command and response records
//   apb_mst_state_e                          : transfer FSM states
//   sat_inc8                                 : saturating 8-bit increment
package apb_master_engine_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned NBYTES_DEF     = DATA_WIDTH_DEF / 8;

    typedef struct packed {
        logic                      write;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
        logic [NBYTES_DEF-1:0]     strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [DATA_WIDTH_DEF-1:0] rdata;
        logic                      slverr;
        logic                      timeout;
    } apb_rsp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_mst_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_master_engine_if.sv
// Bundle of the engine's command/response handshakes and APB bus signals.
//   master modport : engine side (drives cmd_ready, rsp_*, busy, err_count, APB requests)
//   slave  modport : environment side (drives commands, rsp_ready, APB completions)
interface apb_master_engine_if
    import apb_master_engine_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NBYTES     = DATA_WIDTH / 8
);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [NBYTES-1:0]     cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;

    logic                  busy;
    logic [7:0]            err_count;

    logic                  PSELx;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [NBYTES-1:0]     PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  rsp_ready, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output busy, err_count,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output rsp_ready, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  busy, err_count,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_sync_fifo.sv
// First-word fall-through synchronous FIFO.
//   clk_i/rst_i        : clock, asynchronous active-high reset
//   push_i/wdata_i     : write request (ignored when full, even with a pop)
//   pop_i/rdata_o      : read request (ignored when empty); rdata_o shows the head
//   full_o/empty_o     : occupancy flags
//   count_o            : number of stored entries
module apb_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/apb_master_engine.sv
// Queued APB master: commands are buffered, issued as APB transfers with
// wait-state timeout, and each completion is buffered as a response.
//   PCLK/PRESET : clock, asynchronous active-high reset
//   bus         : command/response handshakes, status and APB signals (master modport)
module apb_master_engine
    import apb_master_engine_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int unsigned NBYTES         = DATA_WIDTH / 8,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_engine_if.master bus
);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [NBYTES-1:0]     strb;
    } cmd_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } rsp_t;

    localparam int unsigned CMD_W      = $bits(cmd_t);
    localparam int unsigned RSP_W      = $bits(rsp_t);
    localparam int unsigned CMD_CNT_W  = $clog2(CMD_DEPTH) + 1;
    localparam int unsigned RSP_CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int unsigned WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);

    cmd_t                  cmd_in, cmd_head;
    logic                  cmd_pop, cmd_full, cmd_empty;
    logic [CMD_CNT_W-1:0]  cmd_count;
    rsp_t                  rsp_in, rsp_head;
    logic                  rsp_push, rsp_pop, rsp_full, rsp_empty, rsp_room_after;
    logic [RSP_CNT_W-1:0]  rsp_count;

    apb_mst_state_e        state_q, state_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, ld_pwdata;
    logic [NBYTES-1:0]     pstrb_q, pstrb_d, ld_pstrb;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [7:0]            err_q, err_d;

    assign cmd_in = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_strb};

    apb_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (bus.cmd_valid),
        .wdata_i (cmd_in),
        .pop_i   (cmd_pop),
        .rdata_o (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    apb_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (rsp_push),
        .wdata_i (rsp_in),
        .pop_i   (bus.rsp_ready),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    assign rsp_pop = bus.rsp_ready && !rsp_empty;
    // Room for the next transfer's response once this cycle's push (and any pop) lands.
    assign rsp_room_after = (rsp_count < RSP_CNT_W'(RSP_DEPTH - 1)) || rsp_pop;

    // Reads drive zero data and strobes regardless of what was queued.
    assign ld_pwdata = cmd_head.write ? cmd_head.wdata : '0;
    assign ld_pstrb  = cmd_head.write ? cmd_head.strb  : '0;

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        wait_d    = wait_q;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        rsp_in    = '0;

        unique case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (!cmd_empty && !rsp_full) begin
                    cmd_pop  = 1'b1;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_head.write;
                    paddr_d  = cmd_head.addr;
                    pwdata_d = ld_pwdata;
                    pstrb_d  = ld_pstrb;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_push      = 1'b1;
                    rsp_in.rdata  = pwrite_q ? '0 : bus.PRDATA;
                    rsp_in.slverr = bus.PSLVERR;
                    penable_d     = 1'b0;
                    if (!cmd_empty && rsp_room_after) begin
                        cmd_pop  = 1'b1;
                        pwrite_d = cmd_head.write;
                        paddr_d  = cmd_head.addr;
                        pwdata_d = ld_pwdata;
                        pstrb_d  = ld_pstrb;
                        state_d  = SETUP;
                    end else begin
                        psel_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th ACCESS cycle with PREADY low.
                    rsp_push       = 1'b1;
                    rsp_in.slverr  = 1'b1;
                    rsp_in.timeout = 1'b1;
                    psel_d         = 1'b0;
                    penable_d      = 1'b0;
                    state_d        = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = (rsp_push && rsp_in.slverr) ? sat_inc8(err_q) : err_q;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            wait_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
        end
    end

    assign bus.cmd_ready   = !cmd_full;
    assign bus.rsp_valid   = !rsp_empty;
    assign bus.rsp_rdata   = rsp_head.rdata;
    assign bus.rsp_slverr  = rsp_head.slverr;
    assign bus.rsp_timeout = rsp_head.timeout;
    assign bus.busy        = (state_q != IDLE) || (cmd_count != '0);
    assign bus.err_count   = err_q;
    assign bus.PSELx       = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.PSTRB       = pstrb_q;

endmodule

// File: tb/tb_apb_master_engine.sv
// Self-checking bench for apb_master_engine: table of single transfers
// against a directed slave, plus back-to-back, full-FIFO and reset sequences.
`timescale 1ns/1ps
module tb_apb_master_engine;
    import apb_master_engine_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = 4;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_master_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NBYTES(NB)) bus ();

    apb_master_engine #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NBYTES(NB),
        .CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    // Slave: directed values, or an automatic always-ready responder whose
    // read data and error flag derive from the address.
    logic        auto_slave;
    logic        pready_drv, pslverr_drv;
    logic [31:0] prdata_drv;
    assign bus.PREADY  = auto_slave ? 1'b1 : pready_drv;
    assign bus.PRDATA  = auto_slave ? {16'hC0DE, bus.PADDR[15:0]} : prdata_drv;
    assign bus.PSLVERR = auto_slave ? bus.PADDR[2] : pslverr_drv;

    int unsigned xfers;
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) xfers <= 0;
        else if (bus.PSELx && bus.PENABLE && bus.PREADY) xfers <= xfers + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int unsigned waits;
        logic [31:0] prdata;
        logic        pslverr;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        int unsigned exp_en;
        logic [31:0] exp_rdata;
        logic        exp_slverr;
        logic        exp_timeout;
    } vec_t;

    vec_t        vecs[6];
    int unsigned exp_err;
    apb_rsp_t    exp_q[$];

    task automatic run_vec(input vec_t v);
        int unsigned en;
        bit          seen;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_strb  = v.strb;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.PSELx && !bus.PENABLE) begin
                seen = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        check({v.name, "_setup_seen"}, seen, 1'b1);
        check({v.name, "_pwrite"}, bus.PWRITE, v.write);
        check({v.name, "_paddr"}, bus.PADDR, v.addr);
        check({v.name, "_pwdata"}, bus.PWDATA, v.exp_pwdata);
        check({v.name, "_pstrb"}, bus.PSTRB, v.exp_pstrb);
        en = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge PCLK);
            if (!(bus.PSELx && bus.PENABLE)) break;
            en++;
            pready_drv  = (en > v.waits);
            prdata_drv  = v.prdata;
            pslverr_drv = v.pslverr;
        end
        pready_drv  = 1'b0;
        pslverr_drv = 1'b0;
        prdata_drv  = '0;
        check({v.name, "_penable_cycles"}, en, v.exp_en);
        check({v.name, "_psel_idle"}, bus.PSELx, 1'b0);
        check({v.name, "_paddr_held"}, bus.PADDR, v.addr);
        check({v.name, "_pstrb_held"}, bus.PSTRB, v.exp_pstrb);
        check({v.name, "_rsp_valid"}, bus.rsp_valid, 1'b1);
        check({v.name, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rdata);
        check({v.name, "_rsp_slverr"}, bus.rsp_slverr, v.exp_slverr);
        check({v.name, "_rsp_timeout"}, bus.rsp_timeout, v.exp_timeout);
        if (v.exp_slverr) exp_err++;
        check({v.name, "_err_count"}, bus.err_count, exp_err);
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        check({v.name, "_rsp_popped"}, bus.rsp_valid, 1'b0);
        check({v.name, "_busy"}, bus.busy, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            @(negedge PCLK);
            if (bus.rsp_valid) begin
                apb_rsp_t e;
                e = exp_q.pop_front();
                check({name, "_rdata"}, bus.rsp_rdata, e.rdata);
                check({name, "_slverr"}, bus.rsp_slverr, e.slverr);
                check({name, "_timeout"}, bus.rsp_timeout, e.timeout);
                bus.rsp_ready = 1'b1;
            end else begin
                bus.rsp_ready = 1'b0;
            end
        end
        check({name, "_all_seen"}, exp_q.size(), 0);
        exp_q.delete();
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int unsigned base, run, maxrun, idx;
        bit          seen;

        // name, write, addr, wdata, strb, waits, prdata, pslverr,
        // exp_pwdata, exp_pstrb, exp_en, exp_rdata, exp_slverr, exp_timeout
        vecs[0] = '{"wr_basic",   1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,    32'h77777777, 1'b0,
                    32'hDEADBEEF, 4'hF, 1,  32'h0,        1'b0, 1'b0};
        vecs[1] = '{"rd_wait3",   1'b0, 32'h20, 32'h12345678, 4'hF, 3,    32'hA5A5A5A5, 1'b0,
                    32'h0,        4'h0, 4,  32'hA5A5A5A5, 1'b0, 1'b0};
        vecs[2] = '{"wr_slverr",  1'b1, 32'h24, 32'h0BADF00D, 4'h3, 1,    32'h0,        1'b1,
                    32'h0BADF00D, 4'h3, 2,  32'h0,        1'b1, 1'b0};
        vecs[3] = '{"rd_timeout", 1'b0, 32'h30, 32'hFFFFFFFF, 4'hC, 1000, 32'h55555555, 1'b0,
                    32'h0,        4'h0, 16, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{"rd_after_to",1'b0, 32'h34, 32'h0,        4'h0, 0,    32'h600DCAFE, 1'b0,
                    32'h0,        4'h0, 1,  32'h600DCAFE, 1'b0, 1'b0};
        vecs[5] = '{"rd_slverr",  1'b0, 32'h38, 32'h0,        4'h0, 2,    32'h11112222, 1'b1,
                    32'h0,        4'h0, 3,  32'h11112222, 1'b1, 1'b0};

        PRESET        = 1'b1;
        auto_slave    = 1'b0;
        pready_drv    = 1'b0;
        pslverr_drv   = 1'b0;
        prdata_drv    = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        exp_err       = 0;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;

        check("rst_psel", bus.PSELx, 1'b0);
        check("rst_penable", bus.PENABLE, 1'b0);
        check("rst_pwrite", bus.PWRITE, 1'b0);
        check("rst_paddr", bus.PADDR, 32'h0);
        check("rst_pwdata", bus.PWDATA, 32'h0);
        check("rst_pstrb", bus.PSTRB, 4'h0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_err_count", bus.err_count, 8'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Four back-to-back writes with an always-ready slave.
        auto_slave = 1'b1;
        base   = xfers;
        run    = 0;
        maxrun = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge PCLK);
            if (c < 4) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_write = 1'b1;
                bus.cmd_addr  = 32'h200 + 32'(c * 4);
                bus.cmd_wdata = 32'hA0 + 32'(c);
                bus.cmd_strb  = 4'hF;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (bus.PSELx) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
        end
        check("b2b_psel_run", maxrun, 8);
        check("b2b_xfers", xfers - base, 4);
        for (int i = 0; i < 4; i++) begin
            apb_rsp_t e;
            e.rdata   = '0;
            e.slverr  = (i % 2 == 1);
            e.timeout = 1'b0;
            exp_q.push_back(e);
            if (e.slverr) exp_err++;
        end
        drain("b2b_rsp");
        check("b2b_err_count", bus.err_count, exp_err);

        // Eight reads with responses held: response FIFO fills after 4 transfers.
        base = xfers;
        idx  = 0;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            @(negedge PCLK);
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b0;
            bus.cmd_addr  = 32'h100 + 32'(idx * 4);
            bus.cmd_wdata = '1;
            bus.cmd_strb  = 4'hF;
            if (bus.cmd_ready) idx++;
        end
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        repeat (10) @(negedge PCLK);
        check("full_pushed", idx, 8);
        check("full_xfers", xfers - base, 4);
        check("full_cmd_ready", bus.cmd_ready, 1'b0);
        check("full_psel_idle", bus.PSELx, 1'b0);
        check("full_rsp_valid", bus.rsp_valid, 1'b1);
        check("full_busy", bus.busy, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h1FC;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        check("full_head_rdata", bus.rsp_rdata, 32'hC0DE0100);
        bus.rsp_ready = 1'b1;
        @(negedge PCLK);
        bus.rsp_ready = 1'b0;
        repeat (6) @(negedge PCLK);
        check("full_pop_xfers", xfers - base, 5);
        check("full_pop_psel_idle", bus.PSELx, 1'b0);
        check("full_pop_cmd_ready", bus.cmd_ready, 1'b1);
        for (int i = 1; i < 8; i++) begin
            apb_rsp_t e;
            e.rdata   = 32'hC0DE0100 + 32'(i * 4);
            e.slverr  = (i % 2 == 1);
            e.timeout = 1'b0;
            exp_q.push_back(e);
        end
        exp_err += 4;
        drain("full_rsp");
        repeat (4) @(negedge PCLK);
        check("full_total_xfers", xfers - base, 8);
        check("full_rsp_empty", bus.rsp_valid, 1'b0);
        check("full_busy_done", bus.busy, 1'b0);
        check("full_err_count", bus.err_count, exp_err);

        // Asynchronous reset in the middle of an ACCESS phase.
        auto_slave = 1'b0;
        pready_drv = 1'b0;
        @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h300;
        bus.cmd_wdata = 32'h33;
        bus.cmd_strb  = 4'hF;
        @(negedge PCLK);
        bus.cmd_addr  = 32'h304;
        @(negedge PCLK);
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.PSELx && bus.PENABLE) begin
                seen = 1'b1;
                break;
            end
            @(negedge PCLK);
        end
        check("arst_in_access", seen, 1'b1);
        check("arst_queued_busy", bus.busy, 1'b1);
        #2 PRESET = 1'b1;
        #1;
        check("arst_psel", bus.PSELx, 1'b0);
        check("arst_penable", bus.PENABLE, 1'b0);
        check("arst_paddr", bus.PADDR, 32'h0);
        check("arst_pwdata", bus.PWDATA, 32'h0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_cmd_ready", bus.cmd_ready, 1'b1);
        check("arst_rsp_valid", bus.rsp_valid, 1'b0);
        check("arst_err_count", bus.err_count, 8'h0);
        #1 PRESET = 1'b0;
        repeat (5) @(negedge PCLK);
        check("arst_after_psel", bus.PSELx, 1'b0);
        check("arst_after_rsp_valid", bus.rsp_valid, 1'b0);
        check("arst_after_busy", bus.busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_engine.md
Name: apb_master_engine

Overview:
Synthesizable, parametrised APB master that replaces task-driven stimulus with a queued command/response engine. Upstream logic pushes read/write commands into a command FIFO. An FSM issues them as APB transfers, honouring PREADY wait states, PSLVERR and a wait-state timeout. Each completion is pushed into a response FIFO. The block sits between the UART/AES bridge control logic (or a UVM driver) and the APB slave.

Parameters:
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8)
NBYTES, DATA_WIDTH/8, PSTRB width
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort (>=2)

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
cmd_valid  in  1  command push request
cmd_ready  out  1  command FIFO not full
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  transfer address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  NBYTES  write strobes
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  response pop
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_slverr  out  1  PSLVERR sampled, or timeout
rsp_timeout  out  1  transfer aborted by timeout
busy  out  1  FSM not IDLE, or command FIFO not empty
err_count  out  8  saturating count of slverr/timeout responses
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PSTRB  out  NBYTES  APB strobes
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset clears both FIFOs, sets FSM to IDLE, clears the wait counter and err_count. All APB outputs are 0, rsp_valid=0, busy=0, cmd_ready=1.
- Push occurs when cmd_valid && cmd_ready. cmd_ready = !cmd_full. A push while full is ignored. Pop occurs when rsp_valid && rsp_ready. The FIFOs are first-word fall-through, with simultaneous push and pop allowed at any fill level except push-when-full.
- FSM states are IDLE, SETUP and ACCESS. All APB outputs are registered.
- IDLE: if the command FIFO is non-empty and the response FIFO is not full, pop the command, drive PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB, and go to SETUP. Otherwise PSELx=0, PENABLE=0, and the other APB outputs hold their last values.
- SETUP: the next cycle goes to ACCESS with PENABLE=1. Address, control and data stay stable. The wait counter is cleared.
- ACCESS, PREADY=1:
  - Push a response: rdata = PRDATA on reads, 0 on writes; slverr = PSLVERR; timeout = 0.
  - If another command is ready and the response FIFO will have space after this push, go to SETUP back-to-back: PSELx stays 1, PENABLE=0, new command loaded.
  - Otherwise go to IDLE with PSELx=0 and PENABLE=0.
- ACCESS, PREADY=0: increment the wait counter. When it reaches TIMEOUT_CYCLES, push a response {rdata=0, slverr=1, timeout=1}, deassert PSELx/PENABLE, and go to IDLE.
- Minimum transfer is 2 cycles. A completed write appears on rsp_valid 1 cycle after the PREADY cycle.
- On reads, PSTRB=0 and PWDATA=0, regardless of the cmd_strb/cmd_wdata supplied.
- err_count increments on every pushed response with slverr=1, saturating at 255.
- If the response FIFO is full, no new transfer starts. A transfer already in flight always has a reserved slot, so responses are never dropped.
- An asynchronous PRESET assertion mid-transfer drops PSELx/PENABLE immediately. The in-flight command is lost and no response is produced.

Decomposition:
- shared_pkg additions: ADDR_WIDTH/DATA_WIDTH/NBYTES defaults; typedef apb_cmd_t {write, addr, wdata, strb}; typedef apb_rsp_t {rdata, slverr, timeout}; enum apb_mst_state_e {IDLE, SETUP, ACCESS}.
- One sub-module, apb_sync_fifo (parametrised WIDTH/DEPTH, FWFT, full/empty/count, async active-high reset), instantiated twice: commands and responses.

Test Plan:
- Write 0x10/0xDEADBEEF/strb 0xF, PREADY tied 1: PSELx high 2 cycles, PENABLE in the 2nd; response {0, slverr 0, timeout 0}.
- Read 0x20, slave holds PREADY low 3 cycles then drives 0xA5A5A5A5: PENABLE high 4 cycles; rsp_rdata=0xA5A5A5A5; PSTRB=0 throughout.
- 4 back-to-back writes pushed in 4 cycles, PREADY=1: PSELx stays high 8 consecutive cycles; 4 ordered responses; cmd_ready drops while the FIFO holds 4.
- PREADY never asserted (TIMEOUT_CYCLES=16): after 16 ACCESS cycles the response has slverr=1, timeout=1, rdata=0; err_count=1; the next command proceeds normally.
- rsp_ready=0 with 6 commands queued: exactly 4 transfers issue, then the bus idles; popping 1 response issues the 5th transfer.
- PRESET pulsed during ACCESS of a write: outputs go to 0 asynchronously; both FIFOs empty; busy=0; no response.
